pwm_multi_gen: RTL and testbench
================================

# pwm_multi_gen

Multi-channel PWM generator sharing one period counter across `NUM_CH` outputs, with per-channel duty cycle, edge- or center-aligned mode, and double-buffered configuration. Updates apply glitch-free at period boundaries. It is the next generation of our single-channel `pwmGen` and sits between the register/control logic and the output pads or gate drivers. An optional dead-time stage adds complementary outputs.

## Interface
- `NUM_CH`, 4, number of PWM channels (≥1)
- `DATA_WIDTH`, 32, width of the period, duty and counter values
- `DT_WIDTH`, 8, width of the dead-time count (used only with `PWM_DEADTIME_EN`)

- `clk`  in  1  single clock; all logic is on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run enable; low holds the counter at 0 and forces outputs low
- `cfgValid`  in  1  new configuration offered
- `cfgReady`  out  1  high when no update is pending; a transfer occurs when `cfgValid & cfgReady`
- `cfgPeriod`  in  DATA_WIDTH  period in counter steps (P)
- `cfgDuty`  in  NUM_CH*DATA_WIDTH  duty per channel (D[i]); channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `cfgCenter`  in  1  0 = edge-aligned, 1 = center-aligned
- `cfgDeadTime`  in  DT_WIDTH  dead-time cycles (present only with `PWM_DEADTIME_EN`)
- `pwm`  out  NUM_CH  PWM outputs, registered
- `pwmN`  out  NUM_CH  complementary outputs (present only with `PWM_DEADTIME_EN`)
- `periodEnd`  out  1  one-cycle pulse on the last cycle of each period

## Operation
- Configuration goes through three register stages: input → pending → active.
  - On a `cfgValid & cfgReady` transfer, the inputs are captured into the pending registers and `cfgReady` drops.
  - Pending is copied to active on the last cycle of the current period. `cfgReady` rises the following cycle.
  - If the active P is 0 or `en` is low, pending is copied to active on the cycle after capture.
- Edge mode: the counter runs 0 → P-1, then wraps to 0. Period length is P cycles.
- Center mode: the counter counts up 0 → P-1, then down P-2 → 1, and repeats. Period length is 2P-2 cycles. With P = 1 the block behaves as edge mode.
- Output rule: `pwm[i]` is 1 iff `cnt < D[i]`.
  - D = 0 gives constant low.
  - D ≥ P gives constant high, with no glitch at the wrap.
- P = 0 disables the counter: it holds at 0, `pwm` is 0 and `periodEnd` is 0.
- Comparisons are unsigned at full `DATA_WIDTH`. The counter never exceeds P-1.
- A period change takes effect only at a boundary. A period already in progress completes with the old P and D values.
- Reset values:
  - counter 0, direction up
  - `pwm` 0, `pwmN` 0, `periodEnd` 0
  - `cfgReady` 1
  - active and pending P, D and mode all 0
- Reset asserted mid-period clears all state on the next edge. A pending update is discarded.
- `en` falling: counter returns to 0 and outputs go low on the next edge.
- `en` rising: the counter starts at 0 and the first period is complete.

## Timing
- `pwm` is registered one cycle after the counter value it reflects.
  - The first high cycle of `pwm` is 1 cycle after `en` rises, given P > 0 and D > 0.
- `periodEnd` is registered and aligned with the output cycle that shows `cnt = P-1` (edge mode) or `cnt = 1` on the down-count (center mode).
- Capture to active: at least 1 cycle, at most one full period plus 1 cycle.
- Simultaneous `cfgValid & cfgReady` on a boundary cycle: the new values go to pending and apply at the next boundary, not the current one.

## Configuration
- `PWM_DEADTIME_EN` defined:
  - The `pwm_deadtime` stage is instantiated per channel.
  - The rising edge of `pwm[i]` is delayed by `cfgDeadTime` cycles. `pwmN[i]` is the complement, with its own rising edge delayed the same amount.
  - `pwm[i]` and `pwmN[i]` are never high together.
  - A pulse shorter than or equal to the dead time is suppressed.
  - Dead time 0 gives exact complements.
  - `cfgDeadTime` is double-buffered with the rest of the configuration.
- `PWM_DEADTIME_EN` undefined:
  - No `pwmN` or `cfgDeadTime` ports.
  - `pwm` is driven directly by the compare register.

## Structure
- Package `pwm_pkg`:
  - `pwm_mode_e` (`PWM_EDGE`, `PWM_CENTER`)
  - `cnt_dir_e` (`CNT_UP`, `CNT_DOWN`)
  - default parameter constants
- Sub-module `pwm_deadtime`: per-channel dead-time counter and complementary output generation, guarded by the macro.

## Test plan
- Edge, P=4, D={1,2,0,5}, `en`=1 → ch0 `1000` repeating, ch1 `1100`, ch2 constant 0, ch3 constant 1; `periodEnd` every 4 cycles.
- Center, P=5, D[0]=2 → period 8; `pwm[0]` high for the counts {0,1} up and {1} down, i.e. the sequence 1,1,0,0,0,0,0,1 repeating; `periodEnd` on `cnt`=1 down.
- Update at mid-period from P=10,D=5 to P=4,D=1 → the old period finishes, the new one starts at the boundary; `cfgReady` low until 1 cycle after the boundary; a second `cfgValid` is held off.
- P=0 then P=3,D=1 → outputs stay low, the update applies within 1 cycle, `pwm` is `100` repeating.
- `rst` pulsed at counter=2 with an update pending → all outputs 0, `cfgReady`=1, pending discarded, active P=0.
- With `PWM_DEADTIME_EN`: P=10, D=5, dead time 2 → `pwm` high 3 cycles, `pwmN` high 3 cycles, gaps of 2; dead time 6 → `pwm` suppressed.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and default parameters for pwm_multi_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Counter alignment mode held in the active/pending configuration.
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Direction of the shared period counter.
    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_e;

    localparam int c_DEF_NUM_CH     = 4;
    localparam int c_DEF_DATA_WIDTH = 32;
    localparam int c_DEF_DT_WIDTH   = 8;

endpackage
`default_nettype wire

// File: rtl/pwm_deadtime.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_deadtime
//  Description : Per-channel dead-time insertion. Takes the combinational
//                compare result of one channel and produces registered,
//                mutually exclusive pwm / pwmN outputs whose rising edges
//                are delayed by deadTime cycles. Pulses no longer than the
//                dead time are swallowed. Built only when PWM_DEADTIME_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef PWM_DEADTIME_EN
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = c_DEF_DT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cmp,
    input  logic [DT_WIDTH-1:0] deadTime,
    output logic                pwm,
    output logic                pwmN
);

    localparam logic [DT_WIDTH-1:0] c_ONE = DT_WIDTH'(1);

    logic                r_prev;
    logic [DT_WIDTH-1:0] r_run;
    logic                r_pwm;
    logic                r_pwm_n;
    logic [DT_WIDTH-1:0] w_run_now;
    logic                w_settled;

    // Cycles the compare level has been stable, including this one minus one;
    // a level change restarts the count, and it saturates instead of wrapping.
    always_comb begin
        w_run_now = '0;
        if (cmp == r_prev) begin
            w_run_now = (r_run == '1) ? r_run : r_run + c_ONE;
        end
        w_settled = (w_run_now >= deadTime);
    end

    // Level history and outputs; a side is driven only once its level has settled.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_prev  <= 1'b0;
            r_run   <= '0;
            r_pwm   <= 1'b0;
            r_pwm_n <= 1'b0;
        end else begin
            r_prev  <= cmp;
            r_run   <= w_run_now;
            r_pwm   <= cmp & w_settled;
            r_pwm_n <= ~cmp & w_settled;
        end
    end

    assign pwm  = r_pwm;
    assign pwmN = r_pwm_n;

endmodule
`endif
`default_nettype wire

// File: rtl/pwm_multi_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_gen
//  Description : Multi-channel PWM generator with one shared period counter,
//                per-channel duty, edge/center alignment and double-buffered
//                configuration that switches only at period boundaries.
//                Optional dead-time / complementary outputs are enabled by
//                defining the macro PWM_DEADTIME_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int NUM_CH     = c_DEF_NUM_CH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int DT_WIDTH   = c_DEF_DT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         cfgValid,
    output logic                         cfgReady,
    input  logic [DATA_WIDTH-1:0]        cfgPeriod,
    input  logic [NUM_CH*DATA_WIDTH-1:0] cfgDuty,
    input  logic                         cfgCenter,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_WIDTH-1:0]          cfgDeadTime,
    output logic [NUM_CH-1:0]            pwmN,
`endif
    output logic [NUM_CH-1:0]            pwm,
    output logic                         periodEnd
);

    localparam logic [DATA_WIDTH-1:0] c_ONE = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_TWO = DATA_WIDTH'(2);

    // Active configuration drives the counter; pending waits for a boundary.
    logic [DATA_WIDTH-1:0]        r_act_period;
    logic [NUM_CH*DATA_WIDTH-1:0] r_act_duty;
    pwm_mode_e                    r_act_mode;
    logic [DATA_WIDTH-1:0]        r_pend_period;
    logic [NUM_CH*DATA_WIDTH-1:0] r_pend_duty;
    pwm_mode_e                    r_pend_mode;
    logic                         r_pend_full;
`ifdef PWM_DEADTIME_EN
    logic [DT_WIDTH-1:0]          r_act_dt;
    logic [DT_WIDTH-1:0]          r_pend_dt;
`endif

    logic [DATA_WIDTH-1:0]        r_cnt;
    cnt_dir_e                     r_dir;
    logic                         r_period_end;

    logic                         w_xfer;
    logic                         w_run;
    logic                         w_turn;
    logic                         w_top;
    logic                         w_last;
    logic                         w_load;
    logic [NUM_CH-1:0]            w_cmp;

    assign cfgReady = ~r_pend_full;
    assign w_xfer   = cfgValid & ~r_pend_full;
    assign w_run    = en & (r_act_period != '0);
    // Center mode only has a down-count leg when P >= 3; below that it acts as edge mode.
    assign w_turn   = (r_act_mode == PWM_CENTER) && (r_act_period > c_TWO);
    assign w_top    = (r_cnt == r_act_period - c_ONE);
    // An idle counter has no period to finish, so pending may apply right away.
    assign w_load   = r_pend_full & (w_last | ~w_run);

    // Detect the final cycle of the current period.
    always_comb begin
        w_last = 1'b0;
        if (w_run) begin
            if (w_turn) begin
                w_last = (r_dir == CNT_DOWN) && (r_cnt == c_ONE);
            end else begin
                w_last = w_top;
            end
        end
    end

    // Configuration pipeline: input -> pending on handshake, pending -> active at a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_period  <= '0;
            r_act_duty    <= '0;
            r_act_mode    <= PWM_EDGE;
            r_pend_period <= '0;
            r_pend_duty   <= '0;
            r_pend_mode   <= PWM_EDGE;
            r_pend_full   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_pend_period <= cfgPeriod;
                r_pend_duty   <= cfgDuty;
                r_pend_mode   <= cfgCenter ? PWM_CENTER : PWM_EDGE;
                r_pend_full   <= 1'b1;
            end
            if (w_load) begin
                r_act_period  <= r_pend_period;
                r_act_duty    <= r_pend_duty;
                r_act_mode    <= r_pend_mode;
                r_pend_full   <= 1'b0;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    // Dead time follows the same pending/active handoff as the rest of the configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_dt <= '0;
            r_act_dt  <= '0;
        end else begin
            if (w_xfer) begin
                r_pend_dt <= cfgDeadTime;
            end
            if (w_load) begin
                r_act_dt  <= r_pend_dt;
            end
        end
    end
`endif

    // Shared period counter: wraps at the boundary, turns around at the top in center mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_dir <= CNT_UP;
        end else if (!w_run || w_last) begin
            r_cnt <= '0;
            r_dir <= CNT_UP;
        end else if (r_dir == CNT_DOWN) begin
            r_cnt <= r_cnt - c_ONE;
        end else if (w_top) begin
            r_cnt <= r_act_period - c_TWO;
            r_dir <= CNT_DOWN;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // Boundary pulse, registered so it lines up with the outputs of the same counter value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_end <= 1'b0;
        end else begin
            r_period_end <= w_last;
        end
    end

    assign periodEnd = r_period_end;

    // Per-channel unsigned compare against the active duty value.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cmp
            assign w_cmp[gi] = w_run && (r_cnt < r_act_duty[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate

`ifdef PWM_DEADTIME_EN
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dt
            pwm_deadtime #(
                .DT_WIDTH (DT_WIDTH)
            ) u_deadtime (
                .clk      (clk),
                .rst      (rst),
                .en       (w_run),
                .cmp      (w_cmp[gi]),
                .deadTime (r_act_dt),
                .pwm      (pwm[gi]),
                .pwmN     (pwmN[gi])
            );
        end
    endgenerate
`else
    localparam int c_unused_dt_width = DT_WIDTH;

    logic [NUM_CH-1:0] r_pwm;

    // Output register directly behind the compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_cmp;
        end
    end

    assign pwm = r_pwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi_gen
//  Description : Directed self-checking bench for pwm_multi_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_gen;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int DTW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfgValid;
    logic              cfgReady;
    logic [DW-1:0]     cfgPeriod;
    logic [NCH*DW-1:0] cfgDuty;
    logic              cfgCenter;
    logic [NCH-1:0]    pwm;
    logic              periodEnd;
`ifdef PWM_DEADTIME_EN
    logic [DTW-1:0]    cfgDeadTime;
    logic [NCH-1:0]    pwmN;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_multi_gen #(
        .NUM_CH     (NCH),
        .DATA_WIDTH (DW),
        .DT_WIDTH   (DTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfgValid    (cfgValid),
        .cfgReady    (cfgReady),
        .cfgPeriod   (cfgPeriod),
        .cfgDuty     (cfgDuty),
        .cfgCenter   (cfgCenter),
`ifdef PWM_DEADTIME_EN
        .cfgDeadTime (cfgDeadTime),
        .pwmN        (pwmN),
`endif
        .pwm         (pwm),
        .periodEnd   (periodEnd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [DW-1:0] p, input logic [NCH*DW-1:0] d, input logic c);
        cfgPeriod = p;
        cfgDuty   = d;
        cfgCenter = c;
        cfgValid  = 1'b1;
    endtask

    // Stalled-run guard.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_edge [4];
        logic       pe_edge  [4];
        logic [3:0] exp_ctr  [8];
        logic       pe_ctr   [8];
        int         waited;

        exp_edge = '{4'b1011, 4'b1010, 4'b1000, 4'b1000};
        pe_edge  = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_ctr  = '{4'b1011, 4'b1011, 4'b1010, 4'b1010, 4'b0010, 4'b1010, 4'b1010, 4'b1011};
        pe_ctr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst       = 1'b1;
        en        = 1'b0;
        cfgValid  = 1'b0;
        cfgPeriod = '0;
        cfgDuty   = '0;
        cfgCenter = 1'b0;
`ifdef PWM_DEADTIME_EN
        cfgDeadTime = '0;
`endif

        // Reset state
        tick();
        tick();
        check("reset pwm", pwm, 4'h0);
        check("reset periodEnd", periodEnd, 1'b0);
        check("reset cfgReady", cfgReady, 1'b1);
        rst = 1'b0;

        // Edge mode, P=4, D={1,2,0,5}
        offer(8'd4, {8'd5, 8'd0, 8'd2, 8'd1}, 1'b0);
        tick();
        cfgValid = 1'b0;
        check("edge cfgReady after capture", cfgReady, 1'b0);
        tick();
        check("edge cfgReady after idle load", cfgReady, 1'b1);
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("edge pwm k%0d", k), pwm, exp_edge[k % 4]);
            check($sformatf("edge periodEnd k%0d", k), periodEnd, pe_edge[k % 4]);
        end

        // Center mode, P=5, D={2,5,0,4}
        en = 1'b0;
        offer(8'd5, {8'd4, 8'd0, 8'd5, 8'd2}, 1'b1);
        tick();
        cfgValid = 1'b0;
        check("en low forces pwm low", pwm, 4'h0);
        tick();
        en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("center pwm k%0d", k), pwm, exp_ctr[k % 8]);
            check($sformatf("center periodEnd k%0d", k), periodEnd, pe_ctr[k % 8]);
        end

        // Mid-period update: P=10,D=5 -> P=4,D=1, second offer held off
        en = 1'b0;
        offer(8'd10, {4{8'd5}}, 1'b0);
        tick();
        cfgValid = 1'b0;
        tick();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("old period pwm k%0d", k), pwm, 4'hF);
        end
        offer(8'd4, {4{8'd1}}, 1'b0);
        for (int k = 4; k < 10; k++) begin
            tick();
            if (k == 4) begin
                offer(8'd7, {4{8'd3}}, 1'b0);
            end
            check($sformatf("update pwm k%0d", k), pwm, (k < 5) ? 4'hF : 4'h0);
            check($sformatf("update periodEnd k%0d", k), periodEnd, (k == 9) ? 1'b1 : 1'b0);
            check($sformatf("update cfgReady k%0d", k), cfgReady, (k == 9) ? 1'b1 : 1'b0);
        end
        cfgValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("new period pwm k%0d", k), pwm, (k % 4 == 0) ? 4'hF : 4'h0);
            check($sformatf("new period periodEnd k%0d", k), periodEnd, (k % 4 == 3) ? 1'b1 : 1'b0);
        end

        // P=0 then P=3,D=1
        offer(8'd0, '0, 1'b0);
        tick();
        cfgValid = 1'b0;
        waited = 0;
        while (!cfgReady && waited < 12) begin
            tick();
            waited++;
        end
        check("p0 load within bound", (waited < 12) ? 1'b1 : 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("p0 pwm k%0d", k), pwm, 4'h0);
            check($sformatf("p0 periodEnd k%0d", k), periodEnd, 1'b0);
        end
        offer(8'd3, {4{8'd1}}, 1'b0);
        tick();
        cfgValid = 1'b0;
        check("p3 cfgReady after capture", cfgReady, 1'b0);
        check("p3 pwm before load", pwm, 4'h0);
        tick();
        check("p3 cfgReady after load", cfgReady, 1'b1);
        check("p3 pwm at load", pwm, 4'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("p3 pwm k%0d", k), pwm, (k % 3 == 0) ? 4'hF : 4'h0);
            check($sformatf("p3 periodEnd k%0d", k), periodEnd, (k % 3 == 2) ? 1'b1 : 1'b0);
        end

        // Reset mid-period with an update pending
        offer(8'd6, {4{8'd2}}, 1'b0);
        tick();
        cfgValid = 1'b0;
        check("pre-reset cfgReady", cfgReady, 1'b0);
        check("pre-reset pwm cnt0", pwm, 4'hF);
        tick();
        check("pre-reset pwm cnt1", pwm, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset pwm", pwm, 4'h0);
        check("mid reset periodEnd", periodEnd, 1'b0);
        check("mid reset cfgReady", cfgReady, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("after reset pwm k%0d", k), pwm, 4'h0);
            check($sformatf("after reset periodEnd k%0d", k), periodEnd, 1'b0);
            check($sformatf("after reset cfgReady k%0d", k), cfgReady, 1'b1);
        end

`ifdef PWM_DEADTIME_EN
        begin
            logic [9:0] dt_p;
            logic [9:0] dt_n;
            dt_p = 10'b0011100000;
            dt_n = 10'b0000000111;

            // Dead time 2: three-cycle pulses on each side, two-cycle gaps
            en = 1'b0;
            cfgDeadTime = 8'd2;
            offer(8'd10, {4{8'd5}}, 1'b0);
            tick();
            cfgValid = 1'b0;
            tick();
            en = 1'b1;
            for (int k = 0; k < 20; k++) begin
                tick();
                check($sformatf("dt2 pwm k%0d", k), pwm, dt_p[9 - (k % 10)] ? 4'hF : 4'h0);
                check($sformatf("dt2 pwmN k%0d", k), pwmN, dt_n[9 - (k % 10)] ? 4'hF : 4'h0);
            end

            // Dead time 6: five-cycle pulses are swallowed
            en = 1'b0;
            cfgDeadTime = 8'd6;
            offer(8'd10, {4{8'd5}}, 1'b0);
            tick();
            cfgValid = 1'b0;
            tick();
            en = 1'b1;
            for (int k = 0; k < 20; k++) begin
                tick();
                check($sformatf("dt6 pwm k%0d", k), pwm, 4'h0);
                check($sformatf("dt6 pwmN k%0d", k), pwmN, 4'h0);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
